// File: rtl/sha_msg_padder_if.sv
// Handshake bundle of the SHA-256 message padder: byte-beat input stream and
// 32-bit padded-word output stream.
interface sha_msg_padder_if #(
  parameter int IN_BYTES = 1
);
  localparam int NB_W = $clog2(IN_BYTES + 1);

  logic [8*IN_BYTES-1:0] in_data;
  logic                  in_valid;
  logic                  in_last;
  logic [NB_W-1:0]       in_nbytes;
  logic                  in_ready;
  logic [31:0]           out_word;
  logic                  out_valid;
  logic                  out_ready;
  logic [3:0]            out_idx;
  logic                  out_first;
  logic                  out_last;

  modport slave (
    input  in_data, in_valid, in_last, in_nbytes, out_ready,
    output in_ready, out_word, out_valid, out_idx, out_first, out_last
  );

  modport master (
    output in_data, in_valid, in_last, in_nbytes, out_ready,
    input  in_ready, out_word, out_valid, out_idx, out_first, out_last
  );
endinterface

// File: rtl/sha_msg_padder.sv
// SHA-256 message front end: packs byte beats into big-endian words and appends
// the 0x80 marker, zero fill and 64-bit bit-length, 16 words per block.
module sha_msg_padder #(
  parameter int IN_BYTES = 1,
  parameter int LEN_W    = 64
) (
  input  logic            clk,
  input  logic            reset,
  sha_msg_padder_if.slave bus
);

  generate
    if (!(IN_BYTES == 1 || IN_BYTES == 2 || IN_BYTES == 4)) begin : g_bad_in_bytes
      $error("sha_msg_padder: IN_BYTES must be 1, 2 or 4");
    end
    if (LEN_W < 16 || LEN_W > 64) begin : g_bad_len_w
      $error("sha_msg_padder: LEN_W must be in 16..64");
    end
  endgenerate

  typedef enum logic [2:0] {S_LOAD, S_PAD, S_ZERO, S_LENHI, S_LENLO} state_e;

  state_e           state_q, state_d;
  logic [31:0]      asm_q, asm_d;
  logic [1:0]       bcnt_q, bcnt_d;
  logic [3:0]       widx_q, widx_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             pend_q, pend_d;   // asm_q holds a complete data word not yet in the output register
  logic             extra_q, extra_d;
  logic             first_pend_q, first_pend_d;
  logic [31:0]      out_word_q, out_word_d;
  logic             out_valid_q, out_valid_d;
  logic [3:0]       out_idx_q, out_idx_d;
  logic             out_first_q, out_first_d;
  logic             out_last_q, out_last_d;

  logic        out_free, in_ready, accept;
  logic        ld, ld_last;
  logic [31:0] ld_word, pad_word;
  logic [63:0] len64;
  logic [2:0]  nb_sum;

  assign out_free = !out_valid_q || bus.out_ready;
  assign in_ready = reset && (state_q == S_LOAD) && out_free;
  assign accept   = in_ready && bus.in_valid;
  assign len64    = 64'(len_q);
  assign nb_sum   = {1'b0, bcnt_q} + 3'(bus.in_nbytes);

  always_comb begin
    pad_word = 32'h8000_0000;
    case (bcnt_q)
      2'd1:    pad_word = {asm_q[31:24], 24'h80_0000};
      2'd2:    pad_word = {asm_q[31:16], 16'h8000};
      2'd3:    pad_word = {asm_q[31:8], 8'h80};
      default: pad_word = 32'h8000_0000;
    endcase
  end

  always_comb begin
    // NOTE: every _d takes its _q value first, so no path leaves a variable unassigned (no latches).
    state_d      = state_q;
    asm_d        = asm_q;
    bcnt_d       = bcnt_q;
    widx_d       = widx_q;
    len_d        = len_q;
    pend_d       = pend_q;
    extra_d      = extra_q;
    first_pend_d = first_pend_q;
    out_word_d   = out_word_q;
    out_valid_d  = out_valid_q;
    out_idx_d    = out_idx_q;
    out_first_d  = out_first_q;
    out_last_d   = out_last_q;
    ld           = 1'b0;
    ld_last      = 1'b0;
    ld_word      = 32'h0;

    if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;

    case (state_q)
      S_LOAD: begin
        if (pend_q && out_free) begin
          ld      = 1'b1;
          ld_word = asm_q;
          pend_d  = 1'b0;
          asm_d   = 32'h0;
        end
        if (accept) begin
          // Legal beats never straddle a word, so bcnt_q + in_nbytes <= 4.
          for (int i = 0; i < IN_BYTES; i++) begin
            if (i < int'(bus.in_nbytes) && (int'(bcnt_q) + i) < 4)
              asm_d[8*(3 - int'(bcnt_q) - i) +: 8] = bus.in_data[8*(IN_BYTES-1-i) +: 8];
          end
          len_d  = len_q + LEN_W'({bus.in_nbytes, 3'b000});
          bcnt_d = nb_sum[1:0];
          if (nb_sum[2]) pend_d = 1'b1;
          if (bus.in_last) state_d = S_PAD;
        end
      end
      S_PAD: begin
        if (out_free) begin
          ld     = 1'b1;
          asm_d  = 32'h0;
          if (pend_q) begin
            ld_word = asm_q;
            pend_d  = 1'b0;
          end else begin
            ld_word = pad_word;
            bcnt_d  = 2'd0;
            extra_d = (widx_q >= 4'd14);
            state_d = (widx_q == 4'd13) ? S_LENHI : S_ZERO;
          end
        end
      end
      S_ZERO: begin
        // Leave one word early so the length words follow with no bubble.
        if (out_free) begin
          ld = 1'b1;
          if (widx_q == 4'd13 && !extra_q) state_d = S_LENHI;
        end
      end
      S_LENHI: begin
        if (out_free) begin
          ld      = 1'b1;
          ld_word = len64[63:32];
          state_d = S_LENLO;
        end
      end
      S_LENLO: begin
        if (out_free) begin
          ld      = 1'b1;
          ld_word = len64[31:0];
          ld_last = 1'b1;
          len_d   = '0;
          state_d = S_LOAD;
        end
      end
      default: state_d = S_LOAD;
    endcase

    if (ld) begin
      out_valid_d  = 1'b1;
      out_word_d   = ld_word;
      out_idx_d    = widx_q;
      out_first_d  = first_pend_q;
      out_last_d   = ld_last;
      widx_d       = widx_q + 4'd1;
      first_pend_d = ld_last;
      if (widx_q == 4'd15) extra_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_LOAD;
      asm_q        <= 32'h0;
      bcnt_q       <= 2'd0;
      widx_q       <= 4'd0;
      len_q        <= '0;
      pend_q       <= 1'b0;
      extra_q      <= 1'b0;
      first_pend_q <= 1'b1;
      out_word_q   <= 32'h0;
      out_valid_q  <= 1'b0;
      out_idx_q    <= 4'd0;
      out_first_q  <= 1'b0;
      out_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      asm_q        <= asm_d;
      bcnt_q       <= bcnt_d;
      widx_q       <= widx_d;
      len_q        <= len_d;
      pend_q       <= pend_d;
      extra_q      <= extra_d;
      first_pend_q <= first_pend_d;
      out_word_q   <= out_word_d;
      out_valid_q  <= out_valid_d;
      out_idx_q    <= out_idx_d;
      out_first_q  <= out_first_d;
      out_last_q   <= out_last_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_word  = out_word_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_first = out_first_q;
  assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_sha_msg_padder.sv
// Directed bench for sha_msg_padder: byte-wide and word-wide instances, padding
// boundaries, backpressure and mid-message reset.
module tb_sha_msg_padder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sha_msg_padder_if #(.IN_BYTES(1)) ifa ();
  sha_msg_padder_if #(.IN_BYTES(4)) ifb ();

  sha_msg_padder #(.IN_BYTES(1), .LEN_W(64)) dut_a (.clk(clk), .reset(rst_n), .bus(ifa.slave));
  sha_msg_padder #(.IN_BYTES(4), .LEN_W(64)) dut_b (.clk(clk), .reset(rst_n), .bus(ifb.slave));

  int total = 0;
  int bad   = 0;

  logic [7:0]  msg[$];
  logic [31:0] exp_w[$];
  logic [31:0] got_w[$];
  logic [3:0]  got_i[$];
  logic        got_f[$];
  logic        got_l[$];
  bit          got_last;

  logic        hold_v;
  logic [31:0] hold_w;
  logic [3:0]  hold_i;
  logic        hold_f, hold_l;

  task automatic clear_collect();
    got_w.delete(); got_i.delete(); got_f.delete(); got_l.delete();
    got_last = 1'b0;
    hold_v   = 1'b0;
  endtask

  // Monitor for one cycle: stall stability against last cycle, then record a transfer.
  task automatic note_output(input logic v, input logic r, input logic [31:0] w,
                             input logic [3:0] idx, input logic f, input logic l);
    if (hold_v) begin
      total++;
      if (v !== 1'b1 || w !== hold_w || idx !== hold_i || f !== hold_f || l !== hold_l) begin
        bad++;
        $display("FAIL stall_hold: got v=%b w=%h idx=%0d f=%b l=%b, required v=1 w=%h idx=%0d f=%b l=%b",
                 v, w, idx, f, l, hold_w, hold_i, hold_f, hold_l);
      end
    end
    if (v && r) begin
      got_w.push_back(w); got_i.push_back(idx); got_f.push_back(f); got_l.push_back(l);
      if (l) got_last = 1'b1;
    end
    hold_v = v && !r;
    hold_w = w; hold_i = idx; hold_f = f; hold_l = l;
  endtask

  // Streams msg[] (n bytes; n=0 sends an empty last beat) into the byte-wide instance.
  task automatic drive_a(input int n, input bit rand_ready, input int abort_idx, output bit aborted);
    int  p = 0;
    int  cyc = 0;
    bit  done_in = 1'b0;
    aborted = 1'b0;
    while (!got_last && cyc < 3000) begin
      @(negedge clk);
      ifa.out_ready = rand_ready ? ($urandom_range(0, 9) < 3) : 1'b1;
      if (!done_in) begin
        ifa.in_valid  = 1'b1;
        ifa.in_data   = (n == 0) ? 8'h00 : msg[p];
        ifa.in_nbytes = (n == 0) ? 1'b0 : 1'b1;
        ifa.in_last   = (n == 0) || (p == n - 1);
      end else begin
        ifa.in_valid = 1'b0;
      end
      #1;
      if (abort_idx >= 0 && ifa.out_valid && ifa.out_idx == 4'(abort_idx)) begin
        aborted = 1'b1;
        break;
      end
      if (done_in && !(ifa.out_valid && ifa.out_last)) begin
        total++;
        if (ifa.in_ready !== 1'b0) begin
          bad++;
          $display("FAIL pad_phase_in_ready: got %b, required 0", ifa.in_ready);
        end
      end
      note_output(ifa.out_valid, ifa.out_ready, ifa.out_word, ifa.out_idx, ifa.out_first, ifa.out_last);
      if (ifa.in_valid && ifa.in_ready) begin
        if (ifa.in_last) done_in = 1'b1;
        else p++;
      end
      cyc++;
    end
    ifa.in_valid = 1'b0;
    if (!got_last && !aborted) begin
      total++; bad++;
      $display("FAIL drive_timeout: got %0d words without out_last, required a final word", got_w.size());
    end
  endtask

  task automatic test_reset();
    #2;
    total++;
    if (ifa.out_valid !== 1'b0 || ifa.in_ready !== 1'b0 || ifa.out_word !== 32'h0 ||
        ifa.out_idx !== 4'd0 || ifa.out_first !== 1'b0 || ifa.out_last !== 1'b0) begin
      bad++;
      $display("FAIL reset_a: got v=%b rdy=%b w=%h idx=%0d f=%b l=%b, required all 0",
               ifa.out_valid, ifa.in_ready, ifa.out_word, ifa.out_idx, ifa.out_first, ifa.out_last);
    end
    total++;
    if (ifb.out_valid !== 1'b0 || ifb.in_ready !== 1'b0 || ifb.out_word !== 32'h0) begin
      bad++;
      $display("FAIL reset_b: got v=%b rdy=%b w=%h, required 0 0 00000000",
               ifb.out_valid, ifb.in_ready, ifb.out_word);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (ifa.in_ready !== 1'b1 || ifa.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: got rdy=%b v=%b, required rdy=1 v=0", ifa.in_ready, ifa.out_valid);
    end
  endtask

  task automatic test_abc();
    bit ab;
    msg = '{8'h61, 8'h62, 8'h63};
    exp_w = '{32'h6162_6380};
    repeat (14) exp_w.push_back(32'h0);
    exp_w.push_back(32'h0000_0018);
    clear_collect();
    drive_a(3, 1'b0, -1, ab);
    total++;
    if (got_w.size() != exp_w.size()) begin
      bad++; $display("FAIL abc_count: got %0d words, required %0d", got_w.size(), exp_w.size());
    end
    for (int k = 0; k < exp_w.size() && k < got_w.size(); k++) begin
      total++;
      if (got_w[k] !== exp_w[k] || got_i[k] !== 4'(k % 16) || got_f[k] !== (k == 0) || got_l[k] !== (k == exp_w.size() - 1)) begin
        bad++;
        $display("FAIL abc_word%0d: got %h idx=%0d f=%b l=%b, required %h idx=%0d f=%b l=%b",
                 k, got_w[k], got_i[k], got_f[k], got_l[k], exp_w[k], k % 16, k == 0, k == exp_w.size() - 1);
      end
    end
  endtask

  task automatic test_empty();
    bit ab;
    msg.delete();
    exp_w = '{32'h8000_0000};
    repeat (15) exp_w.push_back(32'h0);
    clear_collect();
    drive_a(0, 1'b0, -1, ab);
    total++;
    if (got_w.size() != exp_w.size()) begin
      bad++; $display("FAIL empty_count: got %0d words, required %0d", got_w.size(), exp_w.size());
    end
    for (int k = 0; k < exp_w.size() && k < got_w.size(); k++) begin
      total++;
      if (got_w[k] !== exp_w[k] || got_i[k] !== 4'(k) || got_f[k] !== (k == 0) || got_l[k] !== (k == 15)) begin
        bad++;
        $display("FAIL empty_word%0d: got %h idx=%0d f=%b l=%b, required %h idx=%0d f=%b l=%b",
                 k, got_w[k], got_i[k], got_f[k], got_l[k], exp_w[k], k, k == 0, k == 15);
      end
    end
  endtask

  // 55 bytes fit one block; 56 bytes force a second block.
  task automatic test_boundary_55_56();
    bit ab;
    for (int c = 0; c < 2; c++) begin
      int n = (c == 0) ? 55 : 56;
      msg.delete();
      repeat (n) msg.push_back(8'h61);
      exp_w.delete();
      repeat (13) exp_w.push_back(32'h6161_6161);
      if (n == 55) begin
        exp_w.push_back(32'h6161_6180);
        exp_w.push_back(32'h0);
        exp_w.push_back(32'h0000_01B8);
      end else begin
        exp_w.push_back(32'h6161_6161);
        exp_w.push_back(32'h8000_0000);
        repeat (16) exp_w.push_back(32'h0);
        exp_w.push_back(32'h0000_01C0);
      end
      clear_collect();
      drive_a(n, 1'b0, -1, ab);
      total++;
      if (got_w.size() != exp_w.size()) begin
        bad++; $display("FAIL len%0d_count: got %0d words, required %0d", n, got_w.size(), exp_w.size());
      end
      for (int k = 0; k < exp_w.size() && k < got_w.size(); k++) begin
        total++;
        if (got_w[k] !== exp_w[k] || got_i[k] !== 4'(k % 16) || got_f[k] !== (k == 0) || got_l[k] !== (k == exp_w.size() - 1)) begin
          bad++;
          $display("FAIL len%0d_word%0d: got %h idx=%0d f=%b l=%b, required %h idx=%0d f=%b l=%b",
                   n, k, got_w[k], got_i[k], got_f[k], got_l[k], exp_w[k], k % 16, k == 0, k == exp_w.size() - 1);
        end
      end
    end
  endtask

  // Word-wide instance: "abcd" full beat then "e" as a 1-byte last beat with junk in the low lanes.
  task automatic test_in4_abcde();
    logic [31:0] bd[2] = '{32'h6162_6364, 32'h65AA_BBCC};
    logic [2:0]  bn[2] = '{3'd4, 3'd1};
    int p = 0;
    int cyc = 0;
    exp_w = '{32'h6162_6364, 32'h6580_0000};
    repeat (13) exp_w.push_back(32'h0);
    exp_w.push_back(32'h0000_0028);
    clear_collect();
    while (!got_last && cyc < 500) begin
      @(negedge clk);
      ifb.out_ready = 1'b1;
      if (p < 2) begin
        ifb.in_valid  = 1'b1;
        ifb.in_data   = bd[p];
        ifb.in_nbytes = bn[p];
        ifb.in_last   = (p == 1);
      end else begin
        ifb.in_valid = 1'b0;
      end
      #1;
      note_output(ifb.out_valid, ifb.out_ready, ifb.out_word, ifb.out_idx, ifb.out_first, ifb.out_last);
      if (ifb.in_valid && ifb.in_ready) p++;
      cyc++;
    end
    ifb.in_valid = 1'b0;
    total++;
    if (got_w.size() != exp_w.size()) begin
      bad++; $display("FAIL in4_count: got %0d words, required %0d", got_w.size(), exp_w.size());
    end
    for (int k = 0; k < exp_w.size() && k < got_w.size(); k++) begin
      total++;
      if (got_w[k] !== exp_w[k] || got_i[k] !== 4'(k) || got_f[k] !== (k == 0) || got_l[k] !== (k == 15)) begin
        bad++;
        $display("FAIL in4_word%0d: got %h idx=%0d f=%b l=%b, required %h idx=%0d f=%b l=%b",
                 k, got_w[k], got_i[k], got_f[k], got_l[k], exp_w[k], k, k == 0, k == 15);
      end
    end
  endtask

  // 200-byte message, first with out_ready held high, then with ~30% out_ready.
  task automatic test_backpressure();
    logic [7:0] pb[$];
    logic [63:0] bits;
    bit ab;
    msg.delete();
    for (int k = 0; k < 200; k++) msg.push_back(8'((k * 7 + 3) & 8'hFF));
    pb = msg;
    pb.push_back(8'h80);
    while (pb.size() % 64 != 56) pb.push_back(8'h00);
    bits = 64'd1600;
    for (int s = 56; s >= 0; s -= 8) pb.push_back(8'(bits >> s));
    exp_w.delete();
    for (int k = 0; k < pb.size(); k += 4) exp_w.push_back({pb[k], pb[k+1], pb[k+2], pb[k+3]});
    for (int mode = 0; mode < 2; mode++) begin
      clear_collect();
      drive_a(200, mode == 1, -1, ab);
      total++;
      if (got_w.size() != exp_w.size()) begin
        bad++; $display("FAIL bp%0d_count: got %0d words, required %0d", mode, got_w.size(), exp_w.size());
      end
      for (int k = 0; k < exp_w.size() && k < got_w.size(); k++) begin
        total++;
        if (got_w[k] !== exp_w[k] || got_i[k] !== 4'(k % 16) || got_f[k] !== (k == 0) || got_l[k] !== (k == exp_w.size() - 1)) begin
          bad++;
          $display("FAIL bp%0d_word%0d: got %h idx=%0d f=%b l=%b, required %h idx=%0d f=%b l=%b",
                   mode, k, got_w[k], got_i[k], got_f[k], got_l[k], exp_w[k], k % 16, k == 0, k == exp_w.size() - 1);
        end
      end
    end
    ifa.out_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    bit ab;
    msg.delete();
    repeat (100) msg.push_back(8'h5A);
    clear_collect();
    drive_a(100, 1'b0, 7, ab);
    total++;
    if (!ab) begin
      bad++; $display("FAIL midreset_reach: got no word at idx 7, required one");
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (ifa.out_valid !== 1'b0 || ifa.out_word !== 32'h0 || ifa.in_ready !== 1'b0 ||
        ifa.out_idx !== 4'd0 || ifa.out_first !== 1'b0 || ifa.out_last !== 1'b0) begin
      bad++;
      $display("FAIL midreset_async: got v=%b w=%h rdy=%b idx=%0d f=%b l=%b, required all 0",
               ifa.out_valid, ifa.out_word, ifa.in_ready, ifa.out_idx, ifa.out_first, ifa.out_last);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      total++;
      if (ifa.out_valid !== 1'b0) begin
        bad++; $display("FAIL midreset_idle%0d: got out_valid=%b, required 0", c, ifa.out_valid);
      end
    end
    test_abc();
  endtask

  initial begin
    ifa.in_valid = 1'b0; ifa.in_last = 1'b0; ifa.in_data = '0; ifa.in_nbytes = '0; ifa.out_ready = 1'b1;
    ifb.in_valid = 1'b0; ifb.in_last = 1'b0; ifb.in_data = '0; ifb.in_nbytes = '0; ifb.out_ready = 1'b1;
    clear_collect();
    test_reset();
    test_abc();
    test_empty();
    test_boundary_55_56();
    test_in4_abcde();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sha_msg_padder.md
Name: sha_msg_padder

Overview:
Synthesizable SHA-256 message front end. It accepts a byte-oriented message stream over a valid/ready handshake, with a configurable beat width. It emits the FIPS 180-4 padded message as a stream of 32-bit big-endian words, 16 per 512-bit block, for the hash core's schedule loader. It replaces the file-driven byte feeder and its single-bit stall/end signalling with a real backpressured interface, an explicit partial last beat, and in-hardware padding and length insertion.

Parameters:
IN_BYTES, 1, bytes per input beat; legal values 1, 2, 4 (elaboration error otherwise).
LEN_W, 64, width of the internal message bit-length counter; legal range 16..64; zero-extended into the 64-bit length field.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
in_data  input  8*IN_BYTES  message bytes; first byte in the MS byte lane
in_valid  input  1  beat valid
in_last  input  1  final beat of the message
in_nbytes  input  $clog2(IN_BYTES+1)  valid bytes in the beat; must equal IN_BYTES unless in_last; 0 is legal only with in_last
in_ready  output  1  padder accepts a beat this cycle
out_word  output  32  padded message word, big-endian
out_valid  output  1  out_word valid
out_ready  input  1  downstream accepts the word
out_idx  output  4  word index within the block, 0..15
out_first  output  1  word 0 of the first block of a message
out_last  output  1  word 15 of the final block, which is the low length word

Behaviour:
- Reset (reset=0, async): out_valid=0, in_ready=0, out_word=0, out_idx=0, out_first=0, out_last=0. Byte count, word index and length counter are cleared. State=LOAD. Reset mid-message discards all partial state; there is no output after release until new input arrives.
- Transfer rules: an input transfer occurs when in_valid&in_ready. An output transfer occurs when out_valid&out_ready. out_word, out_idx, out_first and out_last are held stable while out_valid&!out_ready.
- Internal state: 32-bit assembly register asm, byte count bcnt (0..3), word index widx (0..15), bit-length counter len, flag first_pend (set on reset and after each out_last transfer), flag extra.
- States:
  - LOAD: in_ready = !out_valid | out_ready. On each beat, append the in_nbytes bytes MS-first at bcnt, and add 8*in_nbytes to len modulo 2^LEN_W. When bcnt reaches 4, load the output register next cycle (1-cycle latency), then widx++ and bcnt=0. If in_last, go to PAD; a word completed by the same beat is still emitted first.
  - PAD: in_ready=0. Write 0x80 at byte bcnt and zero the lower bytes, then emit the word. Set extra=1 if this word's widx>=14. Go to ZERO.
  - ZERO: emit 0x00000000 words while widx!=14 or extra. Clear extra when widx wraps 15->0. Go to LENHI when widx==14 and extra==0.
  - LENHI: emit len[63:32] (zero-extended). Then LENLO: emit len[31:0] with out_last=1. Return to LOAD.
- PAD, ZERO and LEN words each issue one per cycle while the output register is free; there are no bubbles under continuous out_ready.
- widx wraps 15->0 on each output transfer of index 15. out_idx=widx of the word held.
- out_first=1 on the first word emitted after first_pend.
- Boundary cases:
  - 55-byte remainder: pad fits, single block.
  - 56..63-byte remainder: adds a second block.
  - Remainder of exactly 64: full data block, then a pad block starting 0x80000000.
  - Empty message (in_last, in_nbytes=0, bcnt=0): single block 80000000, 14 zero words (idx 1..14 in total 13 zeros plus LENHI), length 0.
  - len overflow beyond 2^LEN_W-1 wraps silently.
- Simultaneous events: an in_last beat that completes a word while out_valid&out_ready: accept, emit the data word, then PAD next free cycle.
- Input is ignored in PAD/ZERO/LENHI/LENLO, since in_ready=0 there.

Test Plan:
- "abc" (IN_BYTES=1), out_ready=1 -> 16 words: 61626380, 13×00000000, 00000000, 00000018; out_first on idx0, out_last on idx15, 1 block.
- Empty message (IN_BYTES=1, in_last, in_nbytes=0) -> 80000000, 14×0, 00000000 at idx14... exactly: idx0=80000000, idx1..14=0, idx15=00000000; out_last on idx15.
- 55 bytes of 0x61 -> word13=61616180, word14=0, word15=000001B8, one block. 56 bytes -> word14=80000000, word15=0, then block 2 idx0..13=0, idx14=0, idx15=000001C0.
- IN_BYTES=4, "abcde" as 61626364 then 65xxxxxx with in_last, in_nbytes=1 -> 61626364, 65800000, 12×0, 0, 00000028.
- Random out_ready (30% duty) on a 200-byte message -> word sequence identical to the out_ready=1 run; no drop or duplication; fields stable while stalled; in_ready low during pad phase.
- reset asserted at word 7 of block 1, then "abc" sent -> outputs go 0 asynchronously; the next stream is exactly the "abc" vector with out_first set.
